rv_muldiv_unit: RTL and testbench



---
 rtl/rv_muldiv_pkg.sv | 39 +++
 rtl/rv_div_step.sv | 22 ++
 rtl/rv_muldiv_unit.sv | 163 ++++++++++++++++
 tb/tb_rv_muldiv_unit.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_muldiv_pkg.sv
// Shared types and op-decode helpers for the RV32IM multiply/divide unit.
package rv_muldiv_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } md_op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MUL,
        ST_DIV,
        ST_FIXUP,
        ST_DONE
    } md_state_e;

    function automatic logic is_div(md_op_e op);
        return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
    endfunction

    function automatic logic is_rem(md_op_e op);
        return op inside {OP_REM, OP_REMU};
    endfunction

    function automatic logic is_signed_rs1(md_op_e op);
        return op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    endfunction

    function automatic logic is_signed_rs2(md_op_e op);
        return op inside {OP_MULH, OP_DIV, OP_REM};
    endfunction

endpackage

// File: rtl/rv_div_step.sv
// One restoring-division step: shift a dividend bit into the partial remainder
// and subtract the divisor if it fits.
module rv_div_step #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] part_rem,
    input  logic [XLEN-1:0] divisor,
    input  logic            dividend_bit,
    output logic [XLEN-1:0] next_rem,
    output logic            quo_bit
);

    logic [XLEN:0] shifted;
    logic [XLEN:0] diff;

    // part_rem < divisor always holds, so a borrow shows up in the top bit of diff
    assign shifted  = {part_rem, dividend_bit};
    assign diff     = shifted - {1'b0, divisor};
    assign quo_bit  = ~diff[XLEN];
    assign next_rem = quo_bit ? diff[XLEN-1:0] : {part_rem[XLEN-2:0], dividend_bit};

endmodule

// File: rtl/rv_muldiv_unit.sv
// M-extension execution unit: single-cycle multiply, iterative restoring divide
// with DIV_BITS quotient bits per cycle, start/busy/done handshake and kill.
module rv_muldiv_unit
    import rv_muldiv_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int DIV_BITS = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_i,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] rs2_i,
    input  logic            kill_i,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o
);

    localparam int ITER  = XLEN / DIV_BITS;
    localparam int CNT_W = (ITER > 1) ? $clog2(ITER) : 1;

    md_state_e       state_q, state_d;
    md_op_e          op_q, op_in;
    logic [XLEN-1:0] opa_q, opb_q, rem_q, quo_q, result_q;
    logic            neg_quo_q, neg_rem_q;
    logic [CNT_W-1:0] cnt_q;

    logic            accept, rs1_neg, rs2_neg, div_zero, div_ovf;
    logic [XLEN-1:0] rs1_mag, rs2_mag;

    assign op_in    = md_op_e'(funct3_i);
    assign accept   = (state_q == ST_IDLE) && start_i && !kill_i;
    assign rs1_neg  = is_signed_rs1(op_in) & rs1_i[XLEN-1];
    assign rs2_neg  = is_signed_rs2(op_in) & rs2_i[XLEN-1];
    assign rs1_mag  = rs1_neg ? -rs1_i : rs1_i;
    assign rs2_mag  = rs2_neg ? -rs2_i : rs2_i;
    assign div_zero = (rs2_i == '0);
    assign div_ovf  = is_signed_rs1(op_in) && (rs1_i == {1'b1, {(XLEN-1){1'b0}}}) && (rs2_i == '1);

    logic [2*XLEN-1:0] mul_a, mul_b, product;
    logic [XLEN-1:0]   mul_res;

    assign mul_a   = is_signed_rs1(op_q) ? {{XLEN{opa_q[XLEN-1]}}, opa_q} : {{XLEN{1'b0}}, opa_q};
    assign mul_b   = is_signed_rs2(op_q) ? {{XLEN{opb_q[XLEN-1]}}, opb_q} : {{XLEN{1'b0}}, opb_q};
    assign product = mul_a * mul_b;
    assign mul_res = (op_q == OP_MUL) ? product[XLEN-1:0] : product[2*XLEN-1:XLEN];

    // Dividend bits leave quo_q at the top while quotient bits enter at the bottom
    logic [XLEN-1:0]     rem_chain [0:DIV_BITS];
    logic [DIV_BITS-1:0] q_bits;
    logic [XLEN-1:0]     quo_next;

    assign rem_chain[0] = rem_q;

    for (genvar k = 0; k < DIV_BITS; k++) begin : g_step
        rv_div_step #(.XLEN(XLEN)) u_step (
            .part_rem     (rem_chain[k]),
            .divisor      (opb_q),
            .dividend_bit (quo_q[XLEN-1-k]),
            .next_rem     (rem_chain[k+1]),
            .quo_bit      (q_bits[DIV_BITS-1-k])
        );
    end

    assign quo_next = {quo_q[XLEN-DIV_BITS-1:0], q_bits};

    logic [XLEN-1:0] quo_fix, rem_fix, fix_res;

    assign quo_fix = neg_quo_q ? -quo_q : quo_q;
    assign rem_fix = neg_rem_q ? -rem_q : rem_q;
    assign fix_res = is_rem(op_q) ? rem_fix : quo_fix;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Corner-case divides pass through FIXUP with preset values so they share MUL latency
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (!is_div(op_in))          state_d = ST_MUL;
                    else if (div_zero || div_ovf) state_d = ST_FIXUP;
                    else                          state_d = ST_DIV;
                end
            end
            ST_MUL:   state_d = kill_i ? ST_IDLE : ST_DONE;
            ST_DIV: begin
                if (kill_i)             state_d = ST_IDLE;
                else if (cnt_q == '0)   state_d = ST_FIXUP;
            end
            ST_FIXUP: state_d = kill_i ? ST_IDLE : ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q      <= OP_MUL;
            opa_q     <= '0;
            opb_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            cnt_q     <= '0;
            result_q  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        op_q      <= op_in;
                        opa_q     <= rs1_i;
                        opb_q     <= rs2_i;
                        rem_q     <= '0;
                        quo_q     <= '0;
                        neg_quo_q <= 1'b0;
                        neg_rem_q <= 1'b0;
                        cnt_q     <= CNT_W'(ITER - 1);
                        if (is_div(op_in)) begin
                            if (div_zero) begin
                                quo_q <= '1;
                                rem_q <= rs1_i;
                            end else if (div_ovf) begin
                                quo_q <= rs1_i;
                            end else begin
                                quo_q     <= rs1_mag;
                                opb_q     <= rs2_mag;
                                neg_quo_q <= rs1_neg ^ rs2_neg;
                                neg_rem_q <= rs1_neg;
                            end
                        end
                    end
                end
                ST_MUL: begin
                    if (!kill_i) result_q <= mul_res;
                end
                ST_DIV: begin
                    rem_q <= rem_chain[DIV_BITS];
                    quo_q <= quo_next;
                    cnt_q <= cnt_q - CNT_W'(1);
                end
                ST_FIXUP: begin
                    if (!kill_i) result_q <= fix_res;
                end
                default: ;
            endcase
        end
    end

    assign busy_o   = (state_q == ST_MUL) || (state_q == ST_DIV) || (state_q == ST_FIXUP);
    assign done_o   = (state_q == ST_DONE);
    assign result_o = result_q;

endmodule

// File: tb/tb_rv_muldiv_unit.sv
// Self-checking bench for rv_muldiv_unit: arithmetic reference model, per-cycle
// scoreboard compare, directed corner cases and randomized traffic.
module tb_rv_muldiv_unit;

    localparam int XLEN     = 32;
    localparam int DIV_BITS = 1;
    localparam int ITER     = XLEN / DIV_BITS;

    localparam logic [2:0] F_MUL    = 3'b000;
    localparam logic [2:0] F_MULH   = 3'b001;
    localparam logic [2:0] F_MULHSU = 3'b010;
    localparam logic [2:0] F_MULHU  = 3'b011;
    localparam logic [2:0] F_DIV    = 3'b100;
    localparam logic [2:0] F_DIVU   = 3'b101;
    localparam logic [2:0] F_REM    = 3'b110;
    localparam logic [2:0] F_REMU   = 3'b111;

    logic            clk = 1'b0;
    logic            rst;
    logic            start_i;
    logic [2:0]      funct3_i;
    logic [XLEN-1:0] rs1_i;
    logic [XLEN-1:0] rs2_i;
    logic            kill_i;
    logic            busy_o;
    logic            done_o;
    logic [XLEN-1:0] result_o;

    int errors     = 0;
    int checks     = 0;
    int cyc        = 0;
    int free_cycle = 0;
    logic [31:0] last_res;

    typedef struct packed {
        int          start_c;
        int          end_c;
        logic        done_due;
        logic [31:0] res;
    } exp_t;

    exp_t exp_q[$];

    rv_muldiv_unit #(.XLEN(XLEN), .DIV_BITS(DIV_BITS)) dut (
        .clk      (clk),
        .rst      (rst),
        .start_i  (start_i),
        .funct3_i (funct3_i),
        .rs1_i    (rs1_i),
        .rs2_i    (rs2_i),
        .kill_i   (kill_i),
        .busy_o   (busy_o),
        .done_o   (done_o),
        .result_o (result_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model straight from the RISC-V M-extension rules
    function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        logic [63:0] ua, ub, p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        case (op)
            F_MUL:    begin p = ua * ub;                 return p[31:0];  end
            F_MULH:   begin p = 64'(sa) * 64'(sb);       return p[63:32]; end
            F_MULHSU: begin p = 64'(sa) * ub;            return p[63:32]; end
            F_MULHU:  begin p = ua * ub;                 return p[63:32]; end
            F_DIV: begin
                if (b == 0) return 32'hFFFFFFFF;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return a;
                return 32'(sa / sb);
            end
            F_DIVU:   return (b == 0) ? 32'hFFFFFFFF : a / b;
            F_REM: begin
                if (b == 0) return a;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h0;
                return 32'(sa % sb);
            end
            default:  return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int ref_latency(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        if (!op[2]) return 2;
        if (b == 0) return 2;
        if (!op[0] && a == 32'h80000000 && b == 32'hFFFFFFFF) return 2;
        return ITER + 2;
    endfunction

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, required 0x%08h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Per-cycle compare of busy/done/result against the scoreboard
    initial begin
        logic busy_exp;
        last_res = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_q.delete();
                last_res = '0;
            end else if (exp_q.size() > 0 && exp_q[0].end_c == cyc) begin
                check_output("done_at_end", done_o, exp_q[0].done_due);
                check_output("busy_at_end", busy_o, 0);
                if (exp_q[0].done_due) begin
                    check_output("result", result_o, exp_q[0].res);
                    last_res = exp_q[0].res;
                end else begin
                    check_output("result_after_kill", result_o, last_res);
                end
                exp_q.delete(0);
            end else begin
                busy_exp = (exp_q.size() > 0) && (cyc > exp_q[0].start_c);
                check_output("busy", busy_o, busy_exp);
                check_output("no_done", done_o, 0);
                check_output("result_hold", result_o, last_res);
            end
        end
    end

    task automatic wait_free();
        int guard = 0;
        while (cyc < free_cycle && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (cyc < free_cycle) begin
            checks++;
            errors++;
            $display("[TB] FAIL wait_free: still at cycle %0d, required %0d", cyc, free_cycle);
        end
    endtask

    // kill_off: -1 none, 0 kill together with start, >0 kill that many cycles after start
    task automatic apply_stimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input int kill_off);
        int n, lat, end_c;
        logic due;
        wait_free();
        n   = cyc;
        lat = ref_latency(op, a, b);
        start_i  = 1'b1;
        funct3_i = op;
        rs1_i    = a;
        rs2_i    = b;
        kill_i   = (kill_off == 0);
        if (kill_off == 0) begin
            @(negedge clk);
            start_i    = 1'b0;
            kill_i     = 1'b0;
            free_cycle = cyc;
            return;
        end
        due   = !(kill_off > 0 && kill_off < lat);
        end_c = due ? n + lat : n + kill_off + 1;
        exp_q.push_back('{start_c: n, end_c: end_c, done_due: due, res: ref_result(op, a, b)});
        @(negedge clk);
        start_i = 1'b0;
        rs1_i   = $urandom();
        rs2_i   = $urandom();
        if (kill_off > 0) begin
            while (cyc < n + kill_off) @(negedge clk);
            kill_i = 1'b1;
            @(negedge clk);
            kill_i = 1'b0;
        end
        free_cycle = due ? end_c + 1 : end_c;
    endtask

    task automatic apply_directed(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic [31:0] lit);
        check_output("model_pin", ref_result(op, a, b), lit);
        apply_stimulus(op, a, b, -1);
    endtask

    task automatic hold_start_test(input logic [31:0] a, input logic [31:0] b);
        int n, lat;
        wait_free();
        n   = cyc;
        lat = ref_latency(F_DIV, a, b);
        exp_q.push_back('{start_c: n, end_c: n + lat, done_due: 1'b1, res: ref_result(F_DIV, a, b)});
        start_i  = 1'b1;
        funct3_i = F_DIV;
        rs1_i    = a;
        rs2_i    = b;
        while (cyc < n + lat) begin
            @(negedge clk);
            funct3_i = 3'($urandom_range(0, 7));
            rs1_i    = $urandom();
            rs2_i    = $urandom();
        end
        start_i    = 1'b0;
        free_cycle = n + lat + 1;
    endtask

    task automatic reset_test();
        int n;
        wait_free();
        n = cyc;
        exp_q.push_back('{start_c: n, end_c: n + ITER + 2, done_due: 1'b1, res: ref_result(F_DIVU, 32'hDEADBEEF, 32'h13)});
        start_i  = 1'b1;
        funct3_i = F_DIVU;
        rs1_i    = 32'hDEADBEEF;
        rs2_i    = 32'h13;
        @(negedge clk);
        start_i = 1'b0;
        while (cyc < n + 8) @(negedge clk);
        #3 rst = 1'b1;
        #1;
        check_output("rst_async_busy", busy_o, 0);
        check_output("rst_async_done", done_o, 0);
        check_output("rst_async_result", result_o, 0);
        @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        free_cycle = cyc;
    endtask

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 5))
            0:       return 32'($urandom_range(0, 15));
            1:       return 32'hFFFFFFFF - 32'($urandom_range(0, 15));
            2:       return 32'h80000000;
            default: return $urandom();
        endcase
    endfunction

    initial begin
        logic [2:0]  op;
        logic [31:0] a, b;
        int          kill_off;

        rst      = 1'b0;
        start_i  = 1'b0;
        kill_i   = 1'b0;
        funct3_i = '0;
        rs1_i    = '0;
        rs2_i    = '0;
        #1 rst = 1'b1;
        #1;
        check_output("reset_busy", busy_o, 0);
        check_output("reset_done", done_o, 0);
        check_output("reset_result", result_o, 0);
        repeat (3) @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        free_cycle = cyc;

        check_output("lat_pin_div", ref_latency(F_DIV, 32'hFFFFFFF9, 32'h2), 34);
        check_output("lat_pin_mulh", ref_latency(F_MULH, 32'hFFFFFFFF, 32'h2), 2);
        check_output("lat_pin_div0", ref_latency(F_DIVU, 32'h1234, 32'h0), 2);

        apply_directed(F_MULH,   32'hFFFFFFFF, 32'h2, 32'hFFFFFFFF);
        apply_directed(F_MUL,    32'hFFFFFFFF, 32'h2, 32'hFFFFFFFE);
        apply_directed(F_MULHSU, 32'hFFFFFFFF, 32'h2, 32'hFFFFFFFF);
        apply_directed(F_MULHU,  32'hFFFFFFFF, 32'h2, 32'h00000001);
        apply_directed(F_DIV,    32'hFFFFFFF9, 32'h2, 32'hFFFFFFFD);
        apply_directed(F_REM,    32'hFFFFFFF9, 32'h2, 32'hFFFFFFFF);
        apply_directed(F_DIVU,   32'd100,      32'd7, 32'd14);
        apply_directed(F_REMU,   32'd100,      32'd7, 32'd2);
        apply_directed(F_DIVU,   32'h1234,     32'h0, 32'hFFFFFFFF);
        apply_directed(F_REMU,   32'h1234,     32'h0, 32'h00001234);
        apply_directed(F_DIV,    32'hFFFFFFFB, 32'h0, 32'hFFFFFFFF);
        apply_directed(F_REM,    32'hFFFFFFFB, 32'h0, 32'hFFFFFFFB);
        apply_directed(F_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000);
        apply_directed(F_REM,    32'h80000000, 32'hFFFFFFFF, 32'h00000000);
        apply_directed(F_DIVU,   32'h80000000, 32'hFFFFFFFF, 32'h00000000);
        apply_directed(F_REM,    32'd7,        32'hFFFFFFFE, 32'd1);

        apply_stimulus(F_DIV, 32'hFFFFFFF9, 32'h2, 5);
        repeat (40) @(negedge clk);
        apply_directed(F_MUL, 32'd3, 32'd5, 32'd15);

        apply_stimulus(F_MUL, 32'd9, 32'd9, 0);
        apply_stimulus(F_MUL, 32'd6, 32'd7, 2);
        apply_stimulus(F_DIVU, 32'd1000, 32'd3, ITER + 1);
        apply_stimulus(F_DIVU, 32'd1000, 32'd0, 1);

        hold_start_test(32'd1000, 32'hFFFFFFFD);
        reset_test();
        apply_directed(F_REMU, 32'd100, 32'd7, 32'd2);

        for (int i = 0; i < 300; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = rand_operand();
            b  = ($urandom_range(0, 7) == 0) ? 32'h0 : rand_operand();
            if ($urandom_range(0, 15) == 0) begin
                a = 32'h80000000;
                b = 32'hFFFFFFFF;
            end
            kill_off = -1;
            if ($urandom_range(0, 9) == 0) kill_off = $urandom_range(0, ref_latency(op, a, b) + 1);
            apply_stimulus(op, a, b, kill_off);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
        end

        wait_free();
        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        errors++;
        $display("[TB] FAIL watchdog: run still active at cycle %0d, required finish", cyc);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
